// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the UART TX arbiter slice: sequencer state
// encoding, default payload width, requester-count limit and the
// round-robin pointer advance helper.
package uart_tx_arbiter_pkg;

  // Sequencer states; the encoding is fixed so that debug taps and
  // checkers can decode the state register directly.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_BUSY = 2'b10,
    ST_WAIT_DONE = 2'b11
  } arb_state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_NUM_REQ    = 4;
  // Index width covers the largest supported requester count.
  localparam int IDX_W          = $clog2(MAX_NUM_REQ);
  // Width of the tx_busy-rise timeout counter.
  localparam int CNT_W          = 3;

  // Pointer after a grant: one past the winner, wrapping at num_req.
  function automatic logic [IDX_W-1:0] rr_next_ptr(input logic [IDX_W-1:0] idx,
                                                    input int             num_req);
    int nxt;
    nxt = ((int'(idx) + 1) >= num_req) ? 0 : (int'(idx) + 1);
    return IDX_W'(nxt);
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter
// Combinational requester selection. Each requester is ranked by its
// distance from the search pointer; the lowest-ranked active requester
// wins. With the pointer tied to zero this degenerates to fixed priority
// (lowest index wins), which is how the top uses it when round-robin is
// not built in.
//
// Ports:
//   req        in   NUM_REQ  active request vector
//   ptr        in   IDX_W    index that gets highest priority
//   grant      out  NUM_REQ  one-hot winner (all zero if no request)
//   grant_idx  out  IDX_W    binary index of the winner
//   any        out  1        at least one request active
module uart_tx_rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int   rank_s;
  int   best_rank_s;
  logic hit_s;

  // Pick the active requester closest to the pointer, then decode it one-hot.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    any         = 1'b0;
    rank_s      = 0;
    best_rank_s = NUM_REQ;
    hit_s       = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      // The pointer is always below NUM_REQ, so the rank is never negative.
      rank_s      = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
      hit_s       = req[j] && (rank_s < best_rank_s);
      best_rank_s = hit_s ? rank_s : best_rank_s;
      grant_idx   = hit_s ? IDX_W'(j) : grant_idx;
      any         = any | hit_s;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = any && (grant_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ requesters. A request of one
// or two bytes is latched and acknowledged on grant, then its bytes are fed
// to the UART TX low byte first through the tx_data_valid / tx_busy
// handshake. If tx_busy does not rise within BUSY_TIMEOUT cycles of an issue
// pulse the same byte is issued again.
//
// Build option: define UART_TX_ARB_RR_EN for round-robin arbitration;
// without it the lowest requester index always wins.
//
// Ports:
//   clk            in   1                     UART TX domain clock
//   rst            in   1                     asynchronous reset, active low
//   req_valid      in   NUM_REQ               per-requester request, held until acked
//   req_data       in   NUM_REQ*2*DATA_WIDTH  payload i at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   req_two_byte   in   NUM_REQ               1 = send both bytes, 0 = low byte only
//   req_ack        out  NUM_REQ               one-cycle pulse when request is latched
//   tx_busy        in   1                     UART TX busy
//   tx_data_valid  out  1                     one-cycle issue pulse to UART TX
//   tx_p_data      out  DATA_WIDTH            byte presented to UART TX
//   arb_busy       out  1                     grant until final byte completes
//   grant_id       out  2                     current / last granted requester
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int BUSY_TIMEOUT = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_two_byte,
  output logic [NUM_REQ-1:0]              req_ack,
  input  logic                            tx_busy,
  output logic                            tx_data_valid,
  output logic [DATA_WIDTH-1:0]           tx_p_data,
  output logic                            arb_busy,
  output logic [IDX_W-1:0]                grant_id
);

  localparam int               PW      = 2 * DATA_WIDTH;
  // Last count value spent in WAIT_BUSY before giving up on tx_busy.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  arb_state_e         state_r, state_nxt_s;
  logic [PW-1:0]      data_r, data_nxt_s;
  logic               two_byte_r, two_byte_nxt_s;
  logic               byte_sel_r, byte_sel_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [NUM_REQ-1:0] ack_nxt_s;
  logic               dv_nxt_s;
  logic [DATA_WIDTH-1:0] pdata_nxt_s;
  logic               abusy_nxt_s;
  logic [IDX_W-1:0]   gid_nxt_s;

  logic [IDX_W-1:0]   ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               any_s;
  logic [PW-1:0]      win_data_s;
  logic               win_two_s;
  logic [DATA_WIDTH-1:0] cur_byte_s;

`ifdef UART_TX_ARB_RR_EN
  logic [IDX_W-1:0] ptr_r;

  // Round-robin pointer: moves one past each winner at grant time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if ((state_r == ST_IDLE) && any_s) begin
      ptr_r <= rr_next_ptr(grant_idx_s, NUM_REQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  uart_tx_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  // Payload and length flag of the winning requester (one-hot mux).
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = win_data_s | ({PW{grant_s[i]}} & req_data[i*PW +: PW]);
    end
  end

  assign win_two_s  = |(req_two_byte & grant_s);
  assign cur_byte_s = byte_sel_r ? data_r[PW-1:DATA_WIDTH] : data_r[DATA_WIDTH-1:0];

  // Sequencer next state and next values of all registered outputs.
  always_comb begin
    state_nxt_s    = state_r;
    data_nxt_s     = data_r;
    two_byte_nxt_s = two_byte_r;
    byte_sel_nxt_s = byte_sel_r;
    cnt_nxt_s      = cnt_r;
    ack_nxt_s      = '0;
    dv_nxt_s       = 1'b0;
    pdata_nxt_s    = tx_p_data;
    abusy_nxt_s    = arb_busy;
    gid_nxt_s      = grant_id;

    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          data_nxt_s     = win_data_s;
          two_byte_nxt_s = win_two_s;
          byte_sel_nxt_s = 1'b0;
          ack_nxt_s      = grant_s;
          gid_nxt_s      = grant_idx_s;
          abusy_nxt_s    = 1'b1;
          // Issue the low byte together with the ack when the UART is free,
          // so ack and the first issue pulse land in the same cycle.
          if (!tx_busy) begin
            dv_nxt_s    = 1'b1;
            pdata_nxt_s = win_data_s[DATA_WIDTH-1:0];
            cnt_nxt_s   = '0;
            state_nxt_s = ST_WAIT_BUSY;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (!tx_busy) begin
          dv_nxt_s    = 1'b1;
          pdata_nxt_s = cur_byte_s;
          cnt_nxt_s   = '0;
          state_nxt_s = ST_WAIT_BUSY;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end

      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r == TO_LAST) begin
          // UART never acknowledged the pulse: issue the same byte again.
          state_nxt_s = ST_ISSUE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (two_byte_r && !byte_sel_r) begin
            // UART is already idle here, so the high byte goes out directly.
            byte_sel_nxt_s = 1'b1;
            dv_nxt_s       = 1'b1;
            pdata_nxt_s    = data_r[PW-1:DATA_WIDTH];
            cnt_nxt_s      = '0;
            state_nxt_s    = ST_WAIT_BUSY;
          end else begin
            abusy_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end

      default: begin
        abusy_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      data_r        <= '0;
      two_byte_r    <= 1'b0;
      byte_sel_r    <= 1'b0;
      cnt_r         <= '0;
      req_ack       <= '0;
      tx_data_valid <= 1'b0;
      tx_p_data     <= '0;
      arb_busy      <= 1'b0;
      grant_id      <= '0;
    end else begin
      state_r       <= state_nxt_s;
      data_r        <= data_nxt_s;
      two_byte_r    <= two_byte_nxt_s;
      byte_sel_r    <= byte_sel_nxt_s;
      cnt_r         <= cnt_nxt_s;
      req_ack       <= ack_nxt_s;
      tx_data_valid <= dv_nxt_s;
      tx_p_data     <= pdata_nxt_s;
      arb_busy      <= abusy_nxt_s;
      grant_id      <= gid_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (2 requesters, 8-bit bytes). Inputs
// change and outputs are sampled on the falling clock edge; the DUT acts on
// the rising edge. The bench plays the UART TX by driving tx_busy by hand.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*2*DW-1:0] req_data;
  logic [NR-1:0]     req_two_byte;
  logic [NR-1:0]     req_ack;
  logic              tx_busy;
  logic              tx_data_valid;
  logic [DW-1:0]     tx_p_data;
  logic              arb_busy;
  logic [1:0]        grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .BUSY_TIMEOUT (7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_two_byte  (req_two_byte),
    .req_ack       (req_ack),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_p_data     (tx_p_data),
    .arb_busy      (arb_busy),
    .grant_id      (grant_id)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  two;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    logic        exp_two;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One request from the table, served with tx_busy low at grant time.
  task automatic run_vec(input vec_t v);
    req_valid    = v.valid;
    req_data     = {v.d1, v.d0};
    req_two_byte = v.two;
    @(negedge clk);
    chk("ack", 32'(req_ack), 32'(v.valid));
    chk("grant_id", 32'(grant_id), 32'(v.exp_gid));
    chk("issue0_dv", 32'(tx_data_valid), 32'd1);
    chk("issue0_byte", 32'(tx_p_data), 32'(v.exp_b0));
    chk("arb_busy_set", 32'(arb_busy), 32'd1);
    // Requester changes its inputs once acked; latched data must survive.
    req_valid    = '0;
    req_two_byte = '0;
    req_data     = 32'hDEAD_BEEF;
    tx_busy      = 1'b1;
    repeat (3) @(negedge clk);
    chk("dv_low_busy", 32'(tx_data_valid), 32'd0);
    chk("byte0_stable", 32'(tx_p_data), 32'(v.exp_b0));
    chk("ack_single", 32'(req_ack), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    if (v.exp_two) begin
      chk("issue1_dv", 32'(tx_data_valid), 32'd1);
      chk("issue1_byte", 32'(tx_p_data), 32'(v.exp_b1));
      chk("arb_busy_mid", 32'(arb_busy), 32'd1);
      tx_busy = 1'b1;
      repeat (2) @(negedge clk);
      chk("byte1_stable", 32'(tx_p_data), 32'(v.exp_b1));
      tx_busy = 1'b0;
      @(negedge clk);
    end else begin
      chk("no_second_issue", 32'(tx_data_valid), 32'd0);
    end
    chk("arb_busy_clr", 32'(arb_busy), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_gid;
    int gap;

    vecs[0] = '{valid: 2'b01, d0: 16'hA55A, d1: 16'h0000, two: 2'b01,
                exp_gid: 2'd0, exp_b0: 8'h5A, exp_b1: 8'hA5, exp_two: 1'b1};
    vecs[1] = '{valid: 2'b10, d0: 16'h0000, d1: 16'h1234, two: 2'b00,
                exp_gid: 2'd1, exp_b0: 8'h34, exp_b1: 8'h00, exp_two: 1'b0};
    vecs[2] = '{valid: 2'b10, d0: 16'h0000, d1: 16'hBEEF, two: 2'b10,
                exp_gid: 2'd1, exp_b0: 8'hEF, exp_b1: 8'hBE, exp_two: 1'b1};
    vecs[3] = '{valid: 2'b01, d0: 16'h00FF, d1: 16'h0000, two: 2'b00,
                exp_gid: 2'd0, exp_b0: 8'hFF, exp_b1: 8'h00, exp_two: 1'b0};
    vecs[4] = '{valid: 2'b01, d0: 16'h8001, d1: 16'h0000, two: 2'b01,
                exp_gid: 2'd0, exp_b0: 8'h01, exp_b1: 8'h80, exp_two: 1'b1};
    // two_byte set only for the idle requester: winner sends one byte.
    vecs[5] = '{valid: 2'b01, d0: 16'h7E81, d1: 16'h0000, two: 2'b10,
                exp_gid: 2'd0, exp_b0: 8'h81, exp_b1: 8'h00, exp_two: 1'b0};

    rst          = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_two_byte = '0;
    tx_busy      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_dv", 32'(tx_data_valid), 32'd0);
    chk("rst_pdata", 32'(tx_p_data), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // tx_busy already high at grant: issue waits for it to fall.
    tx_busy      = 1'b1;
    req_valid    = 2'b01;
    req_data     = {16'h0000, 16'h0033};
    req_two_byte = 2'b00;
    @(negedge clk);
    chk("hold_ack", 32'(req_ack), 32'd1);
    chk("hold_no_dv", 32'(tx_data_valid), 32'd0);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_dv_low", 32'(tx_data_valid), 32'd0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    chk("hold_issue_dv", 32'(tx_data_valid), 32'd1);
    chk("hold_issue_byte", 32'(tx_p_data), 32'h33);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("hold_done", 32'(arb_busy), 32'd0);

    // tx_busy never rises: same byte re-issued after 7 cycles in WAIT_BUSY
    // plus one cycle in ISSUE.
    req_valid = 2'b01;
    req_data  = {16'h0000, 16'h0077};
    @(negedge clk);
    chk("to_first_dv", 32'(tx_data_valid), 32'd1);
    req_valid = '0;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tx_data_valid) begin
        gap = k;
        break;
      end
    end
    chk("to_reissue_gap", 32'(gap), 32'd8);
    chk("to_reissue_byte", 32'(tx_p_data), 32'h77);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("to_done", 32'(arb_busy), 32'd0);

    // Requester 1 pulses for one cycle while busy: never acked or sent.
    req_valid = 2'b01;
    req_data  = {16'h0099, 16'h0044};
    @(negedge clk);
    chk("pulse_ack0", 32'(req_ack), 32'd1);
    req_valid = '0;
    tx_busy   = 1'b1;
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    chk("pulse_no_ack", 32'(req_ack), 32'd0);
    req_valid = '0;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("pulse_done", 32'(arb_busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("pulse_forgotten", 32'({req_ack, tx_data_valid}), 32'd0);
    end

    // Both requesters continuously active, one byte each, from reset.
    rst = 1'b0;
    @(negedge clk);
    rst          = 1'b1;
    req_valid    = 2'b11;
    req_data     = {16'h0022, 16'h0011};
    req_two_byte = 2'b00;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
`ifdef UART_TX_ARB_RR_EN
      exp_gid = 2'(t % 2);
`else
      exp_gid = 2'd0;
`endif
      chk("arb_grant_id", 32'(grant_id), 32'(exp_gid));
      chk("arb_ack", 32'(req_ack), 32'd1 << exp_gid);
      chk("arb_byte", 32'(tx_p_data), (exp_gid == 2'd1) ? 32'h22 : 32'h11);
      if (t == 3) begin
        req_valid = '0;
      end
      tx_busy = 1'b1;
      @(negedge clk);
      tx_busy = 1'b0;
      @(negedge clk);
      chk("b2b_idle_gap", 32'({req_ack, arb_busy}), 32'd0);
    end

    // Reset during WAIT_DONE of a two-byte send from requester 1.
    req_valid    = 2'b10;
    req_data     = {16'hC33C, 16'h0000};
    req_two_byte = 2'b10;
    @(negedge clk);
    chk("mr_grant_id", 32'(grant_id), 32'd1);
    chk("mr_byte0", 32'(tx_p_data), 32'h3C);
    req_valid    = '0;
    req_two_byte = '0;
    tx_busy      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_ack", 32'(req_ack), 32'd0);
    chk("mr_dv", 32'(tx_data_valid), 32'd0);
    chk("mr_pdata", 32'(tx_p_data), 32'd0);
    chk("mr_arb_busy", 32'(arb_busy), 32'd0);
    chk("mr_grant_id0", 32'(grant_id), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mr_no_byte1", 32'({tx_data_valid, arb_busy}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Sequencing controller that shares the single UART transmitter between several on-chip requesters (e.g. register-file read path and ALU result path). Accepts one- or two-byte transmit requests, grants one requester at a time, and feeds bytes to the UART TX through its data_valid/busy handshake, low byte first. Sits between the system controller's response sources and the UART TX top; it is the only block driving the UART TX data_valid and parallel-data inputs.

## Interface
- NUM_REQ, 2: number of requesters (2..4)
- DATA_WIDTH, 8: UART frame payload width
- BUSY_TIMEOUT, 7: cycles to wait for tx_busy to rise after an issue pulse before re-issuing (3-bit counter)

- clk  in  1  system clock (UART TX clock domain)
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester transmit request; held until acked
- req_data  in  NUM_REQ*2*DATA_WIDTH  requester i payload at slice [i*2*DATA_WIDTH +: 2*DATA_WIDTH]; low byte sent first
- req_two_byte  in  NUM_REQ  1 = send both bytes, 0 = low byte only
- req_ack  out  NUM_REQ  one-cycle pulse: request latched, requester may drop/change inputs
- tx_busy  in  1  busy output of UART TX
- tx_data_valid  out  1  one-cycle issue pulse to UART TX
- tx_p_data  out  DATA_WIDTH  byte presented to UART TX; stable from issue until tx_busy falls
- arb_busy  out  1  high from grant until final byte's tx_busy falls
- grant_id  out  2  index of current/last granted requester

## Operation
- All outputs registered. Reset values: req_ack=0, tx_data_valid=0, tx_p_data=0, arb_busy=0, grant_id=0, round-robin pointer=0, state=IDLE.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req_valid, pick winner, latch its 16-bit data and req_two_byte, set byte_sel=0, pulse req_ack[winner], set grant_id, arb_busy=1 -> ISSUE. Else stay.
- ISSUE: if tx_busy=0, drive tx_p_data=selected byte, pulse tx_data_valid, clear timeout counter -> WAIT_BUSY. If tx_busy=1, hold tx_data_valid=0 and wait.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Counter reaches BUSY_TIMEOUT with tx_busy still 0 -> ISSUE (re-issue same byte).
- WAIT_DONE: on tx_busy=0: if two-byte and byte_sel=0, set byte_sel=1 -> ISSUE; else arb_busy=0 -> IDLE.
- Arbitration: see Configuration. Requests arriving while arb_busy=1 wait; they are not acked.
- req_valid dropped before ack: request forgotten, no ack, no byte sent.
- Reset mid-transfer: returns to reset values immediately; pending byte(s) discarded, no ack re-issued.

## Timing
- Request sampled at edge N in IDLE: req_ack and tx_data_valid both high during cycle N+1 (tx_busy=0 case). Grant-to-issue latency 1 cycle.
- tx_data_valid is exactly one cycle wide per byte; never asserted while tx_busy=1.
- Between bytes of a two-byte request: tx_busy falls at edge M, second tx_data_valid high in cycle M+1.
- Back-to-back requests: final tx_busy fall at edge M -> IDLE in cycle M+1, next grant/ack in cycle M+2.
- tx_p_data unchanged from issue until the corresponding tx_busy fall.

## Configuration
- UART_TX_ARB_RR_EN defined: round-robin; search starts at pointer, pointer updates to winner+1 (mod NUM_REQ) on each grant.
- Not defined: fixed priority, lowest index wins; pointer logic absent, req 0 may starve others.

## Structure
- Shared package: state encoding constants (IDLE=2'b00, ISSUE=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11), DATA_WIDTH default, max NUM_REQ.
- One sub-module: uart_tx_rr_arbiter (request vector + pointer in, one-hot grant and index out; fixed priority when macro undefined).

## Test plan
- Reset asserted mid-WAIT_DONE of a two-byte send -> all outputs 0 within the reset, no second byte issued after release.
- req_valid[0]=1, req_data=16'hA55A, two_byte=1 -> tx_p_data 8'h5A issued, after tx_busy fall 8'hA5 issued one cycle later; single req_ack[0] pulse.
- req_valid=2'b11 continuously, one-byte each, RR_EN defined -> grants alternate 0,1,0,1; undefined -> grant_id stays 0.
- tx_busy held high at grant -> tx_data_valid stays low until tx_busy=0, then pulses next cycle.
- Issue pulse with tx_busy never rising -> re-issue of same byte after 7 cycles in WAIT_BUSY.
- req_valid[1] pulsed for 1 cycle while arb_busy=1 -> never acked, never transmitted.
